// File: rtl/serial_add_driver_if.sv
// Parallel operand handshake plus serial adder pins for serial_add_driver.
interface serial_add_driver_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ready;
  logic         busy;
  logic         s_in;
  logic         shift_ctrl;
  logic         adder_clr_n;
  logic         s_out;
  logic [N-1:0] sum;
  logic         done;

  // master: parallel datapath and serial adder side; slave: the driver
  modport master (
    output start, a, b, s_out,
    input  ready, busy, s_in, shift_ctrl, adder_clr_n, sum, done
  );

  modport slave (
    input  start, a, b, s_out,
    output ready, busy, s_in, shift_ctrl, adder_clr_n, sum, done
  );
endinterface

// File: rtl/serial_add_driver.sv
// Serial adder initiator: clears the adder, shifts A then B in LSB-first,
// clocks N add cycles and assembles the returned serial sum.
module serial_add_driver #(
  parameter int N = 4
) (
  input logic               clk,
  input logic               rst,
  serial_add_driver_if.slave bus
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [2:0] {IDLE, CLR, LOAD_A, LOAD_B, ADD, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  ra;
  logic [N-1:0]  rb;
  logic [N-1:0]  acc;
  logic [N-1:0]  acc_nxt;
  logic          last;

  assign last    = (cnt == CW'(N - 1));
  assign acc_nxt = {bus.s_out, acc[N-1:1]};

  // s_in is registered one cycle ahead, so it always equals the live ra[0]/rb[0]
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      ra              <= '0;
      rb              <= '0;
      acc             <= '0;
      bus.ready       <= 1'b1;
      bus.busy        <= 1'b0;
      bus.s_in        <= 1'b0;
      bus.shift_ctrl  <= 1'b0;
      bus.adder_clr_n <= 1'b0;
      bus.sum         <= '0;
      bus.done        <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          bus.adder_clr_n <= 1'b1;
          if (bus.start) begin
            ra              <= bus.a;
            rb              <= bus.b;
            state           <= CLR;
            bus.ready       <= 1'b0;
            bus.busy        <= 1'b1;
            bus.adder_clr_n <= 1'b0;
          end
        end
        CLR: begin
          state           <= LOAD_A;
          cnt             <= '0;
          bus.adder_clr_n <= 1'b1;
          bus.shift_ctrl  <= 1'b1;
          bus.s_in        <= ra[0];
        end
        LOAD_A: begin
          ra <= ra >> 1;
          if (last) begin
            state    <= LOAD_B;
            cnt      <= '0;
            bus.s_in <= rb[0];
          end else begin
            cnt      <= cnt + CW'(1);
            bus.s_in <= ra[1];
          end
        end
        LOAD_B: begin
          rb <= rb >> 1;
          if (last) begin
            state    <= ADD;
            cnt      <= '0;
            bus.s_in <= 1'b0;
          end else begin
            cnt      <= cnt + CW'(1);
            bus.s_in <= rb[1];
          end
        end
        ADD: begin
          acc <= acc_nxt;
          if (last) begin
            state          <= DONE;
            cnt            <= '0;
            bus.shift_ctrl <= 1'b0;
            bus.sum        <= acc_nxt;
            bus.done       <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
          bus.busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_driver.sv
// Scoreboard bench for serial_add_driver at N=4 and N=8 with a behavioural serial adder.
module tb_serial_add_driver;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_add_driver_if #(.N(4)) bus4 ();
  serial_add_driver_if #(.N(8)) bus8 ();

  serial_add_driver #(.N(4)) u4 (.clk(clk), .rst(rst), .bus(bus4));
  serial_add_driver #(.N(8)) u8 (.clk(clk), .rst(rst), .bus(bus8));

  typedef struct {
    logic [7:0]  sum;
    int unsigned due;
  } exp_t;

  exp_t        q4[$];
  exp_t        q8[$];
  int unsigned done_cycs4[$];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned done_cnt4 = 0;
  int unsigned clr_lows4 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic fail(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Behavioural serial adder: first 2N shifts load A then B, later shifts add
  logic [7:0]  sr4;
  logic        c4;
  int unsigned k4;
  always @(posedge clk) begin
    if (!bus4.adder_clr_n) begin
      sr4 <= '0; c4 <= 1'b0; k4 <= 0;
    end else if (bus4.shift_ctrl) begin
      if (k4 < 8) begin
        sr4 <= {bus4.s_in, sr4[7:1]};
        k4  <= k4 + 1;
      end else begin
        c4  <= (sr4[0] & sr4[4]) | (sr4[0] & c4) | (sr4[4] & c4);
        sr4 <= {1'b0, sr4[7:5], 1'b0, sr4[3:1]};
      end
    end
  end
  assign bus4.s_out = sr4[0] ^ sr4[4] ^ c4;

  logic [15:0] sr8;
  logic        c8;
  int unsigned k8;
  always @(posedge clk) begin
    if (!bus8.adder_clr_n) begin
      sr8 <= '0; c8 <= 1'b0; k8 <= 0;
    end else if (bus8.shift_ctrl) begin
      if (k8 < 16) begin
        sr8 <= {bus8.s_in, sr8[15:1]};
        k8  <= k8 + 1;
      end else begin
        c8  <= (sr8[0] & sr8[8]) | (sr8[0] & c8) | (sr8[8] & c8);
        sr8 <= {1'b0, sr8[15:9], 1'b0, sr8[7:1]};
      end
    end
  end
  assign bus8.s_out = sr8[0] ^ sr8[8] ^ c8;

  // Monitors: cyc counts edges; DONE is visible after acceptance edge + 3N+1
  initial forever begin
    exp_t e;
    @(posedge clk); #1;
    if (rst && !bus4.adder_clr_n) clr_lows4++;
    if (bus4.done) begin
      done_cnt4++;
      done_cycs4.push_back(cyc);
      if (q4.size() == 0) fail("unexpected_done4", "done=1 required 0");
      else begin
        e = q4.pop_front();
        check("sum4", 32'(bus4.sum), 32'(e.sum));
        check("latency4", cyc, e.due);
      end
    end
  end

  initial forever begin
    exp_t e;
    @(posedge clk); #1;
    if (bus8.done) begin
      if (q8.size() == 0) fail("unexpected_done8", "done=1 required 0");
      else begin
        e = q8.pop_front();
        check("sum8", 32'(bus8.sum), 32'(e.sum));
        check("latency8", cyc, e.due);
      end
    end
  end

  // All drivers run at #1 after a rising edge
  task automatic accept4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                         input bit keep_start);
    int unsigned t = 0;
    while (!bus4.ready) begin
      @(posedge clk); #1;
      if (++t > 200) begin fail("ready_timeout4", "ready=0 required 1"); return; end
    end
    bus4.a = a; bus4.b = b; bus4.start = 1'b1;
    @(posedge clk); #1;
    q4.push_back('{sum: 8'(s), due: cyc + 13});
    if (!keep_start) bus4.start = 1'b0;
  endtask

  task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s);
    int unsigned t = 0;
    while (!bus8.ready) begin
      @(posedge clk); #1;
      if (++t > 200) begin fail("ready_timeout8", "ready=0 required 1"); return; end
    end
    bus8.a = a; bus8.b = b; bus8.start = 1'b1;
    @(posedge clk); #1;
    q8.push_back('{sum: s, due: cyc + 25});
    bus8.start = 1'b0;
  endtask

  task automatic wait_idle4();
    int unsigned t = 0;
    while (q4.size() != 0 || !bus4.ready) begin
      @(posedge clk); #1;
      if (++t > 200) begin fail("idle_timeout4", "operation did not complete"); return; end
    end
  endtask

  task automatic wait_idle8();
    int unsigned t = 0;
    while (q8.size() != 0 || !bus8.ready) begin
      @(posedge clk); #1;
      if (++t > 200) begin fail("idle_timeout8", "operation did not complete"); return; end
    end
  endtask

  // Called right after acceptance: observation i is cycle i+1 of the operation
  task automatic check_serial4(input logic [3:0] a, input logic [3:0] b);
    int unsigned highs = 0;
    logic        exp_s;
    for (int i = 0; i <= 13; i++) begin
      if (i >= 1 && i <= 4)      exp_s = a[i-1];
      else if (i >= 5 && i <= 8) exp_s = b[i-5];
      else                       exp_s = 1'b0;
      check($sformatf("s_in_c%0d", i + 1), 32'(bus4.s_in), 32'(exp_s));
      check($sformatf("shift_c%0d", i + 1), 32'(bus4.shift_ctrl), 32'(i >= 1 && i <= 12));
      check($sformatf("clr_n_c%0d", i + 1), 32'(bus4.adder_clr_n), 32'(i != 0));
      check($sformatf("busy_c%0d", i + 1), 32'(bus4.busy), 32'd1);
      if (bus4.shift_ctrl) highs++;
      @(posedge clk); #1;
    end
    check("shift_high_cycles", highs, 12);
  endtask

  task automatic check_reset_vals4(input string tag);
    check({tag, "_ready"}, 32'(bus4.ready), 32'd1);
    check({tag, "_busy"}, 32'(bus4.busy), 32'd0);
    check({tag, "_s_in"}, 32'(bus4.s_in), 32'd0);
    check({tag, "_shift"}, 32'(bus4.shift_ctrl), 32'd0);
    check({tag, "_clr_n"}, 32'(bus4.adder_clr_n), 32'd0);
    check({tag, "_sum"}, 32'(bus4.sum), 32'd0);
    check({tag, "_done"}, 32'(bus4.done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d0;
    int unsigned c0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals4("reset");
    check("reset8_sum", 32'(bus8.sum), 32'd0);
    check("reset8_ready", 32'(bus8.ready), 32'd1);
    #1 rst = 1'b1;
    #1 check("clr_n_before_edge", 32'(bus4.adder_clr_n), 32'd0);
    @(posedge clk); #1;
    check("clr_n_after_release", 32'(bus4.adder_clr_n), 32'd1);

    // Basic add with serial pin sequence
    accept4(4'b1010, 4'b0011, 4'b1101, 1'b0);
    check_serial4(4'b1010, 4'b0011);
    wait_idle4();

    // Overflow wraps
    accept4(4'b1111, 4'b0001, 4'b0000, 1'b0);
    wait_idle4();
    accept4(4'b0111, 4'b0111, 4'b1110, 1'b0);
    wait_idle4();

    // start during LOAD_B is ignored
    d0 = done_cnt4;
    accept4(4'b0010, 4'b0010, 4'b0100, 1'b0);
    for (int i = 1; i <= 13; i++) begin
      check($sformatf("busy_rej_ready_c%0d", i), 32'(bus4.ready), 32'd0);
      @(posedge clk); #1;
      if (i == 6) begin bus4.start = 1'b1; bus4.a = 4'b0001; bus4.b = 4'b0001; end
      if (i == 7) bus4.start = 1'b0;
    end
    wait_idle4();
    repeat (20) @(posedge clk);
    #1 check("busy_rej_done_count", done_cnt4 - d0, 1);

    // Reset in the second ADD cycle (cycle 2N+3) aborts the operation
    d0 = done_cnt4;
    accept4(4'b0011, 4'b0100, 4'b0111, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_reset_vals4("midreset");
    q4.delete();
    repeat (3) @(posedge clk);
    #1 check("midreset_hold_clr_n", 32'(bus4.adder_clr_n), 32'd0);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("midreset_release_clr_n", 32'(bus4.adder_clr_n), 32'd1);
    repeat (20) @(posedge clk);
    #1 check("midreset_no_done", done_cnt4 - d0, 0);
    accept4(4'b0101, 4'b0110, 4'b1011, 1'b0);
    wait_idle4();

    // Back-to-back with start held high
    c0 = clr_lows4;
    done_cycs4.delete();
    accept4(4'b1001, 4'b0100, 4'b1101, 1'b1);
    accept4(4'b1100, 4'b1000, 4'b0100, 1'b1);
    accept4(4'b0110, 4'b0011, 4'b1001, 1'b0);
    wait_idle4();
    check("b2b_done_count", done_cycs4.size(), 3);
    if (done_cycs4.size() == 3) begin
      check("b2b_interval1", done_cycs4[1] - done_cycs4[0], 15);
      check("b2b_interval2", done_cycs4[2] - done_cycs4[1], 15);
    end
    check("b2b_clr_lows", clr_lows4 - c0, 3);

    // Random pairs on both widths concurrently
    fork
      for (int i = 0; i < 200; i++) begin
        logic [3:0] ra4, rb4;
        ra4 = 4'($urandom_range(0, 15));
        rb4 = 4'($urandom_range(0, 15));
        accept4(ra4, rb4, ra4 + rb4, 1'b0);
      end
      for (int i = 0; i < 200; i++) begin
        logic [7:0] ra8, rb8;
        ra8 = 8'($urandom_range(0, 255));
        rb8 = 8'($urandom_range(0, 255));
        accept8(ra8, rb8, ra8 + rb8);
      end
    join
    wait_idle4();
    wait_idle8();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
